// File: rtl/layer_sched_if.sv
// Bundle between the layer sequencer, its engines and the shared DRAM port.
// The sequencer takes the slave modport; the host/engine side takes master.
interface layer_sched_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int NUM_LAYERS = 4
);
    localparam int LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    logic                             start;
    logic [NUM_LAYERS-1:0]            layer_mask;
    logic [NUM_LAYERS-1:0]            eng_enable;
    logic [NUM_LAYERS-1:0]            eng_done;
    logic [NUM_LAYERS*ADDR_WIDTH-1:0] eng_addr_rd;
    logic [NUM_LAYERS*ADDR_WIDTH-1:0] eng_addr_wr;
    logic [NUM_LAYERS*DATA_WIDTH-1:0] eng_wdata;
    logic [NUM_LAYERS-1:0]            eng_en_rd;
    logic [NUM_LAYERS-1:0]            eng_en_wr;
    logic [ADDR_WIDTH-1:0]            dram_addr_rd;
    logic [ADDR_WIDTH-1:0]            dram_addr_wr;
    logic [DATA_WIDTH-1:0]            dram_wdata;
    logic                             dram_en_rd;
    logic                             dram_en_wr;
    logic [LAYER_W-1:0]               cur_layer;
    logic                             busy;
    logic                             done;
    logic                             error;

    modport slave (
        input  start, layer_mask, eng_done, eng_addr_rd, eng_addr_wr,
               eng_wdata, eng_en_rd, eng_en_wr,
        output eng_enable, dram_addr_rd, dram_addr_wr, dram_wdata,
               dram_en_rd, dram_en_wr, cur_layer, busy, done, error
    );

    modport master (
        output start, layer_mask, eng_done, eng_addr_rd, eng_addr_wr,
               eng_wdata, eng_en_rd, eng_en_wr,
        input  eng_enable, dram_addr_rd, dram_addr_wr, dram_wdata,
               dram_en_rd, dram_en_wr, cur_layer, busy, done, error
    );
endinterface

// File: rtl/layer_sched.sv
// Sequences the enabled layer engines one after another, hands the shared
// DRAM port to whichever engine is running, and traps engines that hang.
module layer_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int NUM_LAYERS = 4,
    parameter int TIMEOUT    = 1048576,
    parameter int CNT_WIDTH  = 21
) (
    input  logic         clk,
    input  logic         srstn,
    layer_sched_if.slave bus
);
    localparam int LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [LAYER_W-1:0]   LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
    localparam logic [CNT_WIDTH-1:0] WDOG_LAST  = CNT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_LAUNCH,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LAYER_W-1:0]    r_cur;
    logic [LAYER_W-1:0]    w_cur_nxt;
    logic [NUM_LAYERS-1:0] r_mask;
    logic [NUM_LAYERS-1:0] w_mask_nxt;
    logic [CNT_WIDTH-1:0]  r_wdog;
    logic [CNT_WIDTH-1:0]  w_wdog_nxt;
    logic                  w_last;
    logic                  w_sel_en;
    logic                  w_cur_done;
    int                    w_idx;

    assign w_last     = (r_cur == LAST_LAYER);
    assign w_sel_en   = r_mask[r_cur];
    assign w_cur_done = bus.eng_done[r_cur];
    assign w_idx      = int'(r_cur);

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_state <= ST_IDLE;
            r_cur   <= '0;
            r_mask  <= '0;
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_mask  <= w_mask_nxt;
            r_wdog  <= w_wdog_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_mask_nxt  = r_mask;
        w_wdog_nxt  = r_wdog;
        case (r_state)
            ST_IDLE, ST_ERR: begin
                if (bus.start) begin
                    w_mask_nxt  = bus.layer_mask;
                    w_cur_nxt   = '0;
                    w_state_nxt = ST_SEL;
                end
            end
            ST_SEL: begin
                if (w_sel_en) begin
                    w_state_nxt = ST_LAUNCH;
                end else if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cur_nxt = r_cur + 1'b1;
                end
            end
            ST_LAUNCH: begin
                w_wdog_nxt  = '0;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // A done arriving on the final watchdog cycle still counts as success.
                w_wdog_nxt = r_wdog + 1'b1;
                if (w_cur_done) begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_cur_nxt   = r_cur + 1'b1;
                        w_state_nxt = ST_SEL;
                    end
                end else if (r_wdog == WDOG_LAST) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_DONE: begin
                w_cur_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.eng_enable   = '0;
        bus.dram_addr_rd = '0;
        bus.dram_addr_wr = '0;
        bus.dram_wdata   = '0;
        bus.dram_en_rd   = 1'b0;
        bus.dram_en_wr   = 1'b0;
        bus.cur_layer    = r_cur;
        bus.busy         = (r_state == ST_SEL) || (r_state == ST_LAUNCH) || (r_state == ST_RUN);
        bus.done         = (r_state == ST_DONE);
        bus.error        = (r_state == ST_ERR);
        if (r_state == ST_LAUNCH) begin
            bus.eng_enable[r_cur] = 1'b1;
        end
        // Only the running engine reaches DRAM; everyone else is masked to zero.
        if (r_state == ST_RUN) begin
            bus.dram_addr_rd = bus.eng_addr_rd[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
            bus.dram_addr_wr = bus.eng_addr_wr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
            bus.dram_wdata   = bus.eng_wdata[w_idx*DATA_WIDTH +: DATA_WIDTH];
            bus.dram_en_rd   = bus.eng_en_rd[r_cur];
            bus.dram_en_wr   = bus.eng_en_wr[r_cur];
        end
    end
endmodule
